vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Generates the VGA raster timing stream consumed by every draw stage: hcount, vcount, hsync, vsync, hblnk and vblnk.
- Sits at the head of the pixel pipeline and runs off the pixel clock.
- Default timing is 1920x1080@60 (CEA-861, 148.5 MHz pclk).
- All outputs are registered and mutually consistent: every output in a given cycle describes the same raster position.

Parameters:
- H_ACTIVE, 1920, visible pixels per line
- H_FP, 88, horizontal front porch (pclk)
- H_SYNC, 44, hsync width (pclk)
- H_BP, 148, horizontal back porch (pclk)
- V_ACTIVE, 1080, visible lines per frame
- V_FP, 4, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 36, vertical back porch (lines)
- SYNC_POL, 1, active level of o_hsync/o_vsync (1 = positive)

Ports:
- i_pclk  in  1  pixel clock
- i_rst  in  1  asynchronous active-high reset
- i_en  in  1  advance enable; when 0 all outputs hold
- o_hcount  out  12  horizontal position, 0..H_TOTAL-1
- o_vcount  out  12  vertical position, 0..V_TOTAL-1
- o_hsync  out  1  horizontal sync, level per SYNC_POL
- o_vsync  out  1  vertical sync, level per SYNC_POL
- o_hblnk  out  1  horizontal blanking
- o_vblnk  out  1  vertical blanking
- o_frame_start  out  1  one-cycle pulse when outputs wrap to (0,0)

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 2200).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 1125).
  - Both must be ≤ 4096; the check is made at elaboration (generate-time error).
- Reset (asynchronous, active-high, clears immediately):
  - o_hcount=0, o_vcount=0, o_hblnk=0, o_vblnk=0, o_frame_start=0.
  - o_hsync=o_vsync=~SYNC_POL (inactive).
  - Outputs stay there while i_rst=1. First advance occurs on the first rising edge with i_rst=0 and i_en=1.
- Counting, on each rising edge with i_en=1:
  - hcount_nxt = (hcount==H_TOTAL-1) ? 0 : hcount+1.
  - vcount_nxt changes only when hcount==H_TOTAL-1: (vcount==V_TOTAL-1) ? 0 : vcount+1.
  - Counter arithmetic is unsigned 12-bit; wrap is by explicit compare, never by overflow.
- Decode (combinational from hcount_nxt/vcount_nxt, registered together with the counts, so decode latency relative to the counts is 0 cycles):
  - hblnk = hcount ≥ H_ACTIVE.
  - vblnk = vcount ≥ V_ACTIVE.
  - hsync active when H_ACTIVE+H_FP ≤ hcount < H_ACTIVE+H_FP+H_SYNC (default 2008..2051).
  - vsync active when V_ACTIVE+V_FP ≤ vcount < V_ACTIVE+V_FP+V_SYNC (default 1084..1088). vsync switches on line boundaries, simultaneously with the hcount 2199→0 transition.
  - frame_start = 1 for exactly one cycle when registered counts go from (H_TOTAL-1,V_TOTAL-1) to (0,0). It is not asserted by reset release.
- Enable:
  - i_en=0 holds every output, including o_frame_start. If a pulse was showing, it stays high until the next enabled edge, then clears.
  - Stalls add no phase error: the sequence of output tuples is identical to the unstalled sequence with repeats inserted.
- Simultaneous events: the line wrap and frame wrap at (2199,1124) resolve in one edge to (0,0) with frame_start=1, hblnk=0, vblnk=0, vsync inactive.
- Reset mid-frame: all outputs return immediately (asynchronously) to the reset values; no partial pulse.
- No combinational path from any input to any output other than the asynchronous reset.

Test Plan:
- Reset then i_en=1: first edge → hcount=1, vcount=0, all sync/blank inactive. hcount=1919 has hblnk=0. The next cycle shows hcount=1920 with hblnk=1.
- Line timing: count cycles at vcount=0 → hsync active for exactly 44 cycles starting at hcount=2008; period from one hsync rising edge to the next is 2200 cycles. hcount 2199→0 increments vcount 0→1.
- Frame timing: run 2,475,000 cycles → exactly one o_frame_start pulse, 1 cycle wide, coincident with (0,0). vsync active on lines 1084..1088 (5×2200 = 11000 cycles). vblnk active from line 1080 to line 1124.
- Stall: drop i_en for 7 cycles at (2051,1088) → outputs frozen for 7 cycles, hsync and vsync stay active; sequence resumes at (2052,1088) with hsync inactive.
- Async reset mid-frame at (1000,500), asserted between clock edges → outputs reach reset values before the next edge. After release, counting restarts from (0,0) with no frame_start pulse.
- Override parameters (H_ACTIVE=640, H_FP=16, H_SYNC=96, H_BP=48, V_ACTIVE=480, V_FP=10, V_SYNC=2, V_BP=33, SYNC_POL=0) → H_TOTAL=800, V_TOTAL=525. hsync low on hcount 656..751; vsync low on vcount 490..491.

Source files
------------

// File: rtl/vga_timing_if.sv
// Raster timing bundle between the timing generator and the draw stages.
// The generator takes the master side; consumers (and the enable source) take the slave side.
interface vga_timing_if;
    logic        i_en;
    logic [11:0] o_hcount;
    logic [11:0] o_vcount;
    logic        o_hsync;
    logic        o_vsync;
    logic        o_hblnk;
    logic        o_vblnk;
    logic        o_frame_start;

    modport master (
        input  i_en,
        output o_hcount, o_vcount, o_hsync, o_vsync, o_hblnk, o_vblnk, o_frame_start
    );

    modport slave (
        output i_en,
        input  o_hcount, o_vcount, o_hsync, o_vsync, o_hblnk, o_vblnk, o_frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: registered h/v counters with sync and blank decoded
// from the next-state counts, so every output in a cycle describes the same position.
module vga_timing_gen #(
    parameter int H_ACTIVE = 1920,
    parameter int H_FP     = 88,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic        i_pclk,
    input  logic        i_rst,
    vga_timing_if.master tim
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_totals
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 4096");
        end
    endgenerate

    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    // 13-bit thresholds so a boundary equal to 4096 does not alias to 0
    localparam logic [12:0] HS_START = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] HS_END   = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] VS_START = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] VS_END   = 13'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [12:0] HB_START = 13'(H_ACTIVE);
    localparam logic [12:0] VB_START = 13'(V_ACTIVE);

    logic [11:0] hcount_q, hcount_d;
    logic [11:0] vcount_q, vcount_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        hblnk_q, hblnk_d;
    logic        vblnk_q, vblnk_d;
    logic        fstart_q, fstart_d;

    logic [11:0] hcnt_nxt, vcnt_nxt;
    logic [12:0] hx, vx;
    logic        line_end, frame_end;

    always_comb begin
        line_end  = (hcount_q == H_LAST);
        frame_end = line_end && (vcount_q == V_LAST);
        hcnt_nxt  = line_end ? 12'd0 : hcount_q + 12'd1;
        vcnt_nxt  = vcount_q;
        if (line_end) begin
            vcnt_nxt = (vcount_q == V_LAST) ? 12'd0 : vcount_q + 12'd1;
        end
        hx = {1'b0, hcnt_nxt};
        vx = {1'b0, vcnt_nxt};
    end

    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        hsync_d  = hsync_q;
        vsync_d  = vsync_q;
        hblnk_d  = hblnk_q;
        vblnk_d  = vblnk_q;
        fstart_d = fstart_q;
        if (tim.i_en) begin
            hcount_d = hcnt_nxt;
            vcount_d = vcnt_nxt;
            hblnk_d  = (hx >= HB_START);
            vblnk_d  = (vx >= VB_START);
            hsync_d  = ((hx >= HS_START) && (hx < HS_END)) ? SYNC_POL : ~SYNC_POL;
            vsync_d  = ((vx >= VS_START) && (vx < VS_END)) ? SYNC_POL : ~SYNC_POL;
            fstart_d = frame_end;
        end
    end

    always_ff @(posedge i_pclk or posedge i_rst) begin
        if (i_rst) begin
            hcount_q <= 12'd0;
            vcount_q <= 12'd0;
            hsync_q  <= ~SYNC_POL;
            vsync_q  <= ~SYNC_POL;
            hblnk_q  <= 1'b0;
            vblnk_q  <= 1'b0;
            fstart_q <= 1'b0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            hblnk_q  <= hblnk_d;
            vblnk_q  <= vblnk_d;
            fstart_q <= fstart_d;
        end
    end

    assign tim.o_hcount      = hcount_q;
    assign tim.o_vcount      = vcount_q;
    assign tim.o_hsync       = hsync_q;
    assign tim.o_vsync       = vsync_q;
    assign tim.o_hblnk       = hblnk_q;
    assign tim.o_vblnk       = vblnk_q;
    assign tim.o_frame_start = fstart_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 1080p instance and a tiny-raster instance,
// both compared every cycle against a linear-position model, plus literal timing checks.
module tb_vga_timing_gen;
    localparam int BHA = 8, BHF = 2, BHS = 3, BHB = 2;
    localparam int BVA = 6, BVF = 1, BVS = 2, BVB = 2;
    localparam int BHT = BHA + BHF + BHS + BHB;
    localparam int BVT = BVA + BVF + BVS + BVB;
    localparam int TOT_B = BHT * BVT;
    localparam int TOT_A = 2200 * 1125;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_timing_if bus_a();
    vga_timing_if bus_b();

    vga_timing_gen dut_a (.i_pclk(clk), .i_rst(rst), .tim(bus_a.master));

    vga_timing_gen #(
        .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
        .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB),
        .SYNC_POL(1'b0)
    ) dut_b (.i_pclk(clk), .i_rst(rst), .tim(bus_b.master));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Expected outputs from a linear position within the frame.
    function automatic logic [31:0] model_tuple(input int p, input bit fs,
                                                input int ha, input int hf, input int hs, input int hb,
                                                input int va, input int vf, input int vs, input bit pol);
        int ht, h, v;
        logic hsy, vsy;
        ht  = ha + hf + hs + hb;
        h   = p % ht;
        v   = p / ht;
        hsy = (h >= ha + hf && h < ha + hf + hs) ? pol : !pol;
        vsy = (v >= va + vf && v < va + vf + vs) ? pol : !pol;
        return {3'b000, 12'(h), 12'(v), hsy, vsy, (h >= ha), (v >= va), fs};
    endfunction

    function automatic logic [31:0] pack(input logic [11:0] h, input logic [11:0] v, input logic hs,
                                         input logic vs, input logic hb, input logic vb, input logic fs);
        return {3'b000, h, v, hs, vs, hb, vb, fs};
    endfunction

    logic [31:0] tup_a, tup_b;
    assign tup_a = pack(bus_a.o_hcount, bus_a.o_vcount, bus_a.o_hsync, bus_a.o_vsync,
                        bus_a.o_hblnk, bus_a.o_vblnk, bus_a.o_frame_start);
    assign tup_b = pack(bus_b.o_hcount, bus_b.o_vcount, bus_b.o_hsync, bus_b.o_vsync,
                        bus_b.o_hblnk, bus_b.o_vblnk, bus_b.o_frame_start);

    int pa = 0, pb = 0;
    bit fsa = 1'b0, fsb = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pa <= 0; fsa <= 1'b0;
            pb <= 0; fsb <= 1'b0;
        end else begin
            if (bus_a.i_en) begin
                fsa <= (pa == TOT_A - 1);
                pa  <= (pa == TOT_A - 1) ? 0 : pa + 1;
            end
            if (bus_b.i_en) begin
                fsb <= (pb == TOT_B - 1);
                pb  <= (pb == TOT_B - 1) ? 0 : pb + 1;
            end
        end
    end

    always @(negedge clk) begin
        check("model_a", tup_a, model_tuple(pa, fsa, 1920, 88, 44, 148, 1080, 4, 5, 1'b1));
        check("model_b", tup_b, model_tuple(pb, fsb, BHA, BHF, BHS, BHB, BVA, BVF, BVS, 1'b0));
    end

    initial begin
        int hs_cnt, hs_first, nrise, rise0, rise1, fs_cnt, vs_cnt, vb_cnt;
        bit prev_hs, vinc_done, found;
        logic [11:0] ph;
        logic [31:0] saved;

        bus_a.i_en = 1'b0;
        bus_b.i_en = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_a", tup_a, 32'h0);
        check("reset_b", tup_b, 32'h18);

        rst = 1'b0;
        bus_a.i_en = 1'b1;
        bus_b.i_en = 1'b1;
        @(posedge clk); #2;
        check("first_edge_a", tup_a, 32'h20000);
        check("first_edge_b", tup_b, 32'h20018);

        // Horizontal timing of the default raster over the first two lines.
        hs_cnt = 0; hs_first = -1; nrise = 0; rise0 = 0; rise1 = 0;
        prev_hs = 1'b0; vinc_done = 1'b0; ph = bus_a.o_hcount;
        for (int k = 2; k < 4420; k++) begin
            bus_b.i_en = ($urandom_range(0, 3) != 0);
            @(posedge clk); #2;
            if (bus_a.o_vcount == 12'd0 && bus_a.o_hsync) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(bus_a.o_hcount);
            end
            if (bus_a.o_hsync && !prev_hs) begin
                if (nrise == 0) rise0 = k;
                else if (nrise == 1) rise1 = k;
                nrise++;
            end
            prev_hs = bus_a.o_hsync;
            if (bus_a.o_vcount == 12'd0 && bus_a.o_hcount == 12'd1919)
                check("hblnk_at_1919", 32'(bus_a.o_hblnk), 32'd0);
            if (bus_a.o_vcount == 12'd0 && bus_a.o_hcount == 12'd1920)
                check("hblnk_at_1920", 32'(bus_a.o_hblnk), 32'd1);
            if (!vinc_done && ph == 12'd2199) begin
                check("line_wrap_h", 32'(bus_a.o_hcount), 32'd0);
                check("line_wrap_v", 32'(bus_a.o_vcount), 32'd1);
                vinc_done = 1'b1;
            end
            ph = bus_a.o_hcount;
        end
        check("hsync_width", 32'(hs_cnt), 32'd44);
        check("hsync_start", 32'(hs_first), 32'd2008);
        check("hsync_period", 32'(rise1 - rise0), 32'd2200);

        // Stall at the last hsync pixel of the last vsync line of the small raster.
        bus_b.i_en = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            @(posedge clk); #2;
            if (bus_b.o_hcount == 12'd12 && bus_b.o_vcount == 12'd8) found = 1'b1;
        end
        check("stall_reached", 32'(found), 32'd1);
        if (found) begin
            bus_b.i_en = 1'b0;
            saved = tup_b;
            repeat (7) begin
                @(posedge clk); #2;
                check("stall_hold", tup_b, saved);
            end
            check("stall_syncs_active", {30'd0, bus_b.o_hsync, bus_b.o_vsync}, 32'd0);
            bus_b.i_en = 1'b1;
            @(posedge clk); #2;
            check("stall_resume_h", 32'(bus_b.o_hcount), 32'd13);
            check("stall_resume_v", 32'(bus_b.o_vcount), 32'd8);
            check("stall_resume_syncs", {30'd0, bus_b.o_hsync, bus_b.o_vsync}, 32'd2);
        end

        // Three full small frames.
        fs_cnt = 0; vs_cnt = 0; vb_cnt = 0;
        for (int k = 0; k < 3 * TOT_B; k++) begin
            @(posedge clk); #2;
            if (bus_b.o_frame_start) begin
                fs_cnt++;
                check("frame_start_pos", {20'd0, bus_b.o_hcount}, {20'd0, bus_b.o_vcount});
            end
            if (!bus_b.o_vsync) vs_cnt++;
            if (bus_b.o_vblnk) vb_cnt++;
        end
        check("frame_start_count", 32'(fs_cnt), 32'd3);
        check("vsync_cycles", 32'(vs_cnt), 32'(3 * BVS * BHT));
        check("vblnk_cycles", 32'(vb_cnt), 32'(3 * (BVT - BVA) * BHT));

        for (int k = 0; k < 3000; k++) begin
            bus_a.i_en = ($urandom_range(0, 3) != 0);
            bus_b.i_en = ($urandom_range(0, 3) != 0);
            @(posedge clk); #2;
        end

        // Asynchronous reset between edges.
        bus_a.i_en = 1'b1;
        bus_b.i_en = 1'b1;
        rst = 1'b1;
        #1;
        check("async_reset_a", tup_a, 32'h0);
        check("async_reset_b", tup_b, 32'h18);
        @(posedge clk); #2;
        check("reset_hold_b", tup_b, 32'h18);
        rst = 1'b0;
        @(posedge clk); #2;
        check("restart_a", tup_a, 32'h20000);
        check("restart_b", tup_b, 32'h20018);
        repeat (20) @(posedge clk);
        #2;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
